vec_mem_unit: RTL and testbench
===============================

// Module: vec_mem_unit
// PURPOSE
//  Parametrised vector memory-access stage, between the EX/MEM and MEM/WB registers.
//  Replaces the free-running PCMEM counter/compare scheme with an FSM that issues
//  either one scalar access (immediate address) or an N-element strided burst.
//  Drives a synchronous RAM and returns read data tagged with its element index.
// PARAMETERS
//  DATA_W  32  data path / element width
//  ADDR_W   8  RAM address width; address arithmetic wraps mod 2^ADDR_W
//  IMM_W    8  immediate width; IMM_W <= ADDR_W
//  DEST_W   3  destination register index width
//  LEN_W    8  vector length width; max burst = 2^LEN_W-1 elements
//  RD_LAT   1  RAM read latency in cycles (>=1)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst_n         in   1       asynchronous reset, active low
//  start         in   1       request pulse; sampled only in IDLE
//  vec_mode      in   1       0 = scalar (address = immediate), 1 = strided vector
//  wr_req        in   1       1 = write access, 0 = read access
//  sel_data      in   1       write data select: 0 = data1_in, 1 = result_alu
//  data1_in      in   DATA_W  register-file operand
//  result_alu    in   DATA_W  ALU result
//  inmediate_in  in   IMM_W   immediate / scalar address
//  dir_dest_in   in   DEST_W  destination register
//  base_addr     in   ADDR_W  vector base address
//  stride        in   ADDR_W  vector stride (unsigned, wraps)
//  vec_len       in   LEN_W   vector element count
//  mem_q         in   DATA_W  RAM read data
//  mem_addr      out  ADDR_W  RAM address (registered)
//  mem_data      out  DATA_W  RAM write data (registered)
//  mem_wren      out  1       RAM write enable (registered)
//  rd_valid      out  1       rd_data/rd_index valid this cycle
//  rd_data       out  DATA_W  read element
//  rd_index      out  LEN_W   element number of rd_data
//  dir_dest_out  out  DEST_W  destination captured at start
//  inmediate_out out  IMM_W   immediate captured at start
//  busy          out  1       high in any state other than IDLE
//  done          out  1       one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output 0; read-latency pipeline flushed.
//  States: IDLE -> ISSUE -> (DRAIN if read) -> DONE -> IDLE.
//  IDLE: start=1 captures vec_mode, wr_req, base_addr, stride, N, dest, imm;
//   N = vec_len if vec_mode else 1. N=0 -> straight to DONE, no RAM access.
//  ISSUE: one access per cycle, element k=0..N-1; start at cycle T -> element k
//   presented on mem_addr/mem_wren in cycle T+1+k.
//   addr_k = vec_mode ? (base_addr + k*stride) mod 2^ADDR_W : zero-ext(imm).
//   Address generated by running accumulator (addr += stride), no multiplier.
//   Write: mem_data = sel_data ? result_alu : data1_in, sampled live each cycle
//   (upstream supplies one element per cycle); mem_wren=1 only in ISSUE.
//   Read: mem_wren=0; element k returns on rd_valid in cycle T+1+k+RD_LAT,
//   rd_data=mem_q, rd_index=k; index carried through RD_LAT-deep tag pipe.
//  DRAIN (reads only): wait until last element's rd_valid has been presented.
//  DONE: done=1 for exactly one cycle, then IDLE.
//   Write: done at cycle T+1+N. Read: done one cycle after last rd_valid.
//  start while busy=1 is ignored (no queueing). Outputs dir_dest_out and
//   inmediate_out hold captured values until next accepted start.
//  mem_addr/mem_data hold last value when not issuing; mem_wren=0 outside ISSUE.
//  Address wrap: 0xFF + 1 -> 0x00 at ADDR_W=8, no flag, no stall.
//  Reset mid-burst: burst abandoned, no further mem_wren/rd_valid/done.
// TESTING
//  1 scalar read: imm=0x12, RAM[0x12]=0xCAFE0001 -> mem_addr=0x12 at T+1,
//    rd_valid/rd_data=0xCAFE0001/rd_index=0 at T+2, done at T+3 (RD_LAT=1).
//  2 vector write: base=0x10, stride=2, len=4, sel_data=1, ALU=A,B,C,D ->
//    wren at T+1..T+4 to 0x10,0x12,0x14,0x16; done at T+5; RAM holds A..D.
//  3 wrap: base=0xFE, stride=1, len=4 read -> addresses 0xFE,0xFF,0x00,0x01,
//    rd_index 0..3 in order, rd_valid count exactly 4.
//  4 len=0 vector: no wren, no rd_valid, busy 1 cycle, done at T+1.
//  5 start pulsed during busy burst of 3 -> ignored; exactly 3 accesses, one done.
//  6 rst_n low at T+2 of len=8 write -> all outputs 0 immediately, no further
//    wren/done; new start after release runs normally. Repeat 1-3 with RD_LAT=3.

Source files
------------

// File: rtl/vec_mem_unit.sv
// Vector memory-access stage: one scalar access or an N-element strided burst to a sync RAM.
// Element k issued T+1+k after start; read data returns RD_LAT later; no backpressure, start ignored while busy.
module vec_mem_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int IMM_W  = 8,
    parameter int DEST_W = 3,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              vec_mode,
    input  logic              wr_req,
    input  logic              sel_data,
    input  logic [DATA_W-1:0] data1_in,
    input  logic [DATA_W-1:0] result_alu,
    input  logic [IMM_W-1:0]  inmediate_in,
    input  logic [DEST_W-1:0] dir_dest_in,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [LEN_W-1:0]  rd_index,
    output logic [DEST_W-1:0] dir_dest_out,
    output logic [IMM_W-1:0]  inmediate_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic              vec_r, wr_r;
    logic [ADDR_W-1:0] stride_r;
    logic [LEN_W-1:0]  n_r, k_r;
    logic              pipe_vld [RD_LAT];
    logic [LEN_W-1:0]  pipe_idx [RD_LAT];

    logic [LEN_W-1:0]  n_in;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata;
    logic              accept, advance, rd_issue, last_elem, last_rd;

    assign n_in      = vec_mode ? vec_len : LEN_W'(1);
    assign addr0     = vec_mode ? base_addr : ADDR_W'(inmediate_in);
    assign wdata     = sel_data ? result_alu : data1_in;
    assign last_elem = (k_r == n_r - LEN_W'(1));
    assign last_rd   = pipe_vld[RD_LAT-1] && (pipe_idx[RD_LAT-1] == n_r - LEN_W'(1));
    assign rd_issue  = (state == S_ISSUE) && !wr_r;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (n_in == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_elem) state_nxt = wr_r ? S_DONE : S_DRAIN;
                else           advance   = 1'b1;
            end
            S_DRAIN: begin
                if (last_rd) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            vec_r         <= 1'b0;
            wr_r          <= 1'b0;
            stride_r      <= '0;
            n_r           <= '0;
            k_r           <= '0;
            mem_addr      <= '0;
            mem_data      <= '0;
            mem_wren      <= 1'b0;
            dir_dest_out  <= '0;
            inmediate_out <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                vec_r         <= vec_mode;
                wr_r          <= wr_req;
                stride_r      <= stride;
                n_r           <= n_in;
                k_r           <= '0;
                dir_dest_out  <= dir_dest_in;
                inmediate_out <= inmediate_in;
                if (n_in != '0) begin
                    mem_addr <= addr0;
                    mem_wren <= wr_req;
                    if (wr_req) mem_data <= wdata;
                end
            end
            // mem_addr doubles as the running address accumulator
            if (state == S_ISSUE) begin
                if (advance) begin
                    k_r <= k_r + LEN_W'(1);
                    if (vec_r) mem_addr <= mem_addr + stride_r;
                    if (wr_r)  mem_data <= wdata;
                end else begin
                    mem_wren <= 1'b0;
                end
            end
            pipe_vld[0] <= rd_issue;
            pipe_idx[0] <= rd_issue ? k_r : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    assign rd_valid = pipe_vld[RD_LAT-1];
    assign rd_index = pipe_idx[RD_LAT-1];
    assign rd_data  = rd_valid ? mem_q : '0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_vec_mem_unit.sv
// Bench for vec_mem_unit: two instances (RD_LAT=1 and RD_LAT=3) share stimulus, each with its own RAM,
// checked cycle by cycle against expected access/return schedules computed from the address rules.
module tb_vec_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, vec_mode = 1'b0, wr_req = 1'b0, sel_data = 1'b0;
    logic [31:0] data1_in = '0, result_alu = '0;
    logic [7:0]  inmediate_in = '0, base_addr = '0, stride = '0, vec_len = '0;
    logic [2:0]  dir_dest_in = '0;

    logic [7:0]  o1_addr, o3_addr, o1_ri, o3_ri, o1_im, o3_im;
    logic [31:0] o1_data, o3_data, o1_rd, o3_rd, mem_q1, mem_q3;
    logic        o1_wren, o3_wren, o1_rv, o3_rv, o1_busy, o3_busy, o1_done, o3_done;
    logic [2:0]  o1_dd, o3_dd;

    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [31:0] pl_d = '0;
    logic [31:0] ram1 [256];
    logic [31:0] ram3 [256];
    logic [31:0] qp1;
    logic [31:0] qp3 [3];

    logic [31:0] ref_mem [256];
    logic [7:0]  exp_addr [256];
    logic [31:0] wdat [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vec_mem_unit #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_mode(vec_mode), .wr_req(wr_req),
        .sel_data(sel_data), .data1_in(data1_in), .result_alu(result_alu),
        .inmediate_in(inmediate_in), .dir_dest_in(dir_dest_in), .base_addr(base_addr),
        .stride(stride), .vec_len(vec_len), .mem_q(mem_q1), .mem_addr(o1_addr),
        .mem_data(o1_data), .mem_wren(o1_wren), .rd_valid(o1_rv), .rd_data(o1_rd),
        .rd_index(o1_ri), .dir_dest_out(o1_dd), .inmediate_out(o1_im),
        .busy(o1_busy), .done(o1_done));

    vec_mem_unit #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_mode(vec_mode), .wr_req(wr_req),
        .sel_data(sel_data), .data1_in(data1_in), .result_alu(result_alu),
        .inmediate_in(inmediate_in), .dir_dest_in(dir_dest_in), .base_addr(base_addr),
        .stride(stride), .vec_len(vec_len), .mem_q(mem_q3), .mem_addr(o3_addr),
        .mem_data(o3_data), .mem_wren(o3_wren), .rd_valid(o3_rv), .rd_data(o3_rd),
        .rd_index(o3_ri), .dir_dest_out(o3_dd), .inmediate_out(o3_im),
        .busy(o3_busy), .done(o3_done));

    // Synchronous RAMs with 1- and 3-cycle read latency
    always @(posedge clk) begin
        if (pl_en)        ram1[pl_a] <= pl_d;
        else if (o1_wren) ram1[o1_addr] <= o1_data;
        qp1 <= ram1[o1_addr];
    end
    always @(posedge clk) begin
        if (pl_en)        ram3[pl_a] <= pl_d;
        else if (o3_wren) ram3[o3_addr] <= o3_data;
        qp3[0] <= ram3[o3_addr];
        qp3[1] <= qp3[0];
        qp3[2] <= qp3[1];
    end
    assign mem_q1 = qp1;
    assign mem_q3 = qp3[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc_chk(input string p, input int lat, input int j, input int n, input bit wr,
                           input int dj, input logic wren, input logic [7:0] addr,
                           input logic [31:0] data, input logic rv, input logic [31:0] rd,
                           input logic [7:0] ri, input logic dn, input logic bz);
        bit ew, er;
        ew = wr && (j < n);
        er = !wr && (j >= lat) && (j - lat < n);
        check($sformatf("%s_wren_c%0d", p, j), 32'(wren), 32'(ew));
        if (j < n) check($sformatf("%s_addr_c%0d", p, j), 32'(addr), 32'(exp_addr[j]));
        if (ew)    check($sformatf("%s_wdata_c%0d", p, j), data, wdat[j]);
        check($sformatf("%s_rvalid_c%0d", p, j), 32'(rv), 32'(er));
        if (er) begin
            check($sformatf("%s_rindex_c%0d", p, j), 32'(ri), 32'(j - lat));
            check($sformatf("%s_rdata_c%0d", p, j), rd, ref_mem[exp_addr[j - lat]]);
        end
        check($sformatf("%s_done_c%0d", p, j), 32'(dn), 32'(j == dj));
        check($sformatf("%s_busy_c%0d", p, j), 32'(bz), 32'(j <= dj));
    endtask

    task automatic rst_chk(input string p, input logic wren, input logic [7:0] addr,
                           input logic [31:0] data, input logic rv, input logic [31:0] rd,
                           input logic [7:0] ri, input logic [2:0] dd, input logic [7:0] im,
                           input logic dn, input logic bz);
        check({p, "_rst_outputs"},
              {5'(wren) ^ 5'(rv) ^ 5'(dn) ^ 5'(bz), 3'(dd), 8'(addr), 8'(ri), 8'(im)}, 32'd0);
        check({p, "_rst_wdata"}, data, 32'd0);
        check({p, "_rst_rdata"}, rd, 32'd0);
    endtask

    task automatic drive_data(input int k, input int n, input bit sel);
        logic [31:0] d, other;
        d = (k < n) ? wdat[k] : $urandom;
        other = $urandom;
        if (sel) begin result_alu = d;     data1_in = other; end
        else     begin result_alu = other; data1_in = d;     end
    endtask

    task automatic run_op(input bit vec, input bit wr, input bit sel, input logic [7:0] imm,
                          input logic [7:0] base, input logic [7:0] str, input logic [7:0] len,
                          input bit poke);
        int n, d1, d3;
        logic [2:0] dest;
        n = vec ? int'(len) : 1;
        for (int k = 0; k < n; k++) begin
            exp_addr[k] = vec ? 8'((int'(base) + k * int'(str)) % 256) : imm;
            wdat[k] = $urandom;
        end
        d1 = (n == 0) ? 0 : (wr ? n : n + 1);
        d3 = (n == 0) ? 0 : (wr ? n : n + 3);
        dest = 3'($urandom);
        @(negedge clk);
        start = 1'b1; vec_mode = vec; wr_req = wr; sel_data = sel; inmediate_in = imm;
        base_addr = base; stride = str; vec_len = len; dir_dest_in = dest;
        drive_data(0, n, sel);
        @(posedge clk);
        for (int j = 0; j <= d3 + 2; j++) begin
            @(negedge clk);
            cyc_chk("L1", 1, j, n, wr, d1, o1_wren, o1_addr, o1_data, o1_rv, o1_rd, o1_ri,
                    o1_done, o1_busy);
            cyc_chk("L3", 3, j, n, wr, d3, o3_wren, o3_addr, o3_data, o3_rv, o3_rd, o3_ri,
                    o3_done, o3_busy);
            if (wr && j < n) ref_mem[exp_addr[j]] = wdat[j];
            // a start while busy must change nothing that was captured
            start = poke && (j == 0) && (n > 0);
            if (start) begin
                base_addr = 8'($urandom); stride = 8'($urandom); vec_len = 8'($urandom);
                inmediate_in = 8'($urandom); dir_dest_in = 3'($urandom); wr_req = ~wr;
            end
            drive_data(j + 1, n, sel);
        end
        check("L1_dest_hold", 32'(o1_dd), 32'(dest));
        check("L3_dest_hold", 32'(o3_dd), 32'(dest));
        check("L1_imm_hold", 32'(o1_im), 32'(imm));
        check("L3_imm_hold", 32'(o3_im), 32'(imm));
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  base0;
        // preload both RAMs and the model while held in reset
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v = (i == 8'h12) ? 32'hCAFE0001 : $urandom;
            pl_en = 1'b1; pl_a = 8'(i); pl_d = v; ref_mem[i] = v;
        end
        @(negedge clk);
        pl_en = 1'b0;
        rst_chk("L1", o1_wren, o1_addr, o1_data, o1_rv, o1_rd, o1_ri, o1_dd, o1_im, o1_done, o1_busy);
        rst_chk("L3", o3_wren, o3_addr, o3_data, o3_rv, o3_rd, o3_ri, o3_dd, o3_im, o3_done, o3_busy);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(1'b0, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 8'h00, 1'b0);   // scalar read
        run_op(1'b1, 1'b1, 1'b1, 8'h00, 8'h10, 8'h02, 8'd4,  1'b0);   // vector write
        run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h02, 8'd4,  1'b0);   // read it back
        run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'hFE, 8'h01, 8'd4,  1'b0);   // address wrap
        run_op(1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 8'h01, 8'd0,  1'b0);   // empty vector
        run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h01, 8'd0,  1'b0);
        run_op(1'b1, 1'b1, 1'b1, 8'h00, 8'h80, 8'h05, 8'd3,  1'b1);   // start while busy
        run_op(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 8'h05, 8'd3,  1'b1);
        run_op(1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 8'h00, 8'h00, 1'b1);   // scalar write

        // reset in the middle of a length-8 write burst
        base0 = 8'hC0;
        wdat[0] = $urandom;
        @(negedge clk);
        start = 1'b1; vec_mode = 1'b1; wr_req = 1'b1; sel_data = 1'b1; base_addr = base0;
        stride = 8'h01; vec_len = 8'd8; result_alu = wdat[0];
        @(negedge clk);
        start = 1'b0; result_alu = $urandom;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_chk("L1_mid", o1_wren, o1_addr, o1_data, o1_rv, o1_rd, o1_ri, o1_dd, o1_im, o1_done, o1_busy);
        rst_chk("L3_mid", o3_wren, o3_addr, o3_data, o3_rv, o3_rd, o3_ri, o3_dd, o3_im, o3_done, o3_busy);
        ref_mem[base0] = wdat[0];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet_c%0d", j),
                  {28'd0, o1_wren | o3_wren, o1_done | o3_done, o1_busy | o3_busy, o1_rv | o3_rv},
                  32'd0);
        end
        run_op(1'b1, 1'b0, 1'b0, 8'h00, base0, 8'h01, 8'd3, 1'b0);

        for (int r = 0; r < 24; r++) begin
            run_op(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom_range(0, 6)), 1'($urandom));
        end
        check("ram1_holds_vec", ram1[8'h16], ref_mem[8'h16]);
        check("ram3_holds_vec", ram3[8'h10], ref_mem[8'h10]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
